// File: rtl/motor_step_arbiter.sv
// motor_step_arbiter: round-robin arbiter sharing one step-pulse timing engine across motor channels
//   clk_ix, rstn_ix          : system clock, asynchronous active-low reset
//   step_req_b, dir_req_b    : per-channel step request level and requested direction
//   pfail_b                  : per-channel power-fail, aborts an in-flight step in SETUP/HIGH
//   pl_clk_b, pl_dir_b       : step pulse and registered direction to each driver
//   step_ack_b, step_abort_b : one-cycle completed-step / aborted-step flags
//   busy_o                   : timing engine not idle
module motor_step_arbiter #(
    parameter int NMOTORS        = 16,
    parameter int DIR_SETUP_CYC  = 8,
    parameter int PULSE_HIGH_CYC = 20,
    parameter int PULSE_LOW_CYC  = 20
) (
    input  logic               clk_ix,
    input  logic               rstn_ix,
    input  logic [NMOTORS-1:0] step_req_b,
    input  logic [NMOTORS-1:0] dir_req_b,
    input  logic [NMOTORS-1:0] pfail_b,
    output logic [NMOTORS-1:0] pl_clk_b,
    output logic [NMOTORS-1:0] pl_dir_b,
    output logic [NMOTORS-1:0] step_ack_b,
    output logic [NMOTORS-1:0] step_abort_b,
    output logic               busy_o
);
    localparam int PW = (NMOTORS > 1) ? $clog2(NMOTORS) : 1;
    // zero-length phases are stretched to one cycle
    localparam logic [15:0] LD_S = 16'((DIR_SETUP_CYC > 1) ? DIR_SETUP_CYC - 1 : 0);
    localparam logic [15:0] LD_H = 16'((PULSE_HIGH_CYC > 1) ? PULSE_HIGH_CYC - 1 : 0);
    localparam logic [15:0] LD_L = 16'((PULSE_LOW_CYC > 1) ? PULSE_LOW_CYC - 1 : 0);
    localparam logic [NMOTORS-1:0] ONE = NMOTORS'(1);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
    state_t             state, state_n;
    logic [15:0]        cnt, cnt_n;
    logic [PW-1:0]      ptr, ptr_n, gnt, gnt_n, win, idx;
    logic               found, aborted, aborted_n, abort_now;
    logic [NMOTORS-1:0] elig, dir_n, clk_n, ack_n, abt_n;

    assign elig   = step_req_b & ~pfail_b;
    assign busy_o = state != IDLE;

    // scan from farthest to nearest so the channel closest to ptr+1 is the last assignment and wins
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NMOTORS; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NMOTORS);
            if (elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        gnt_n     = gnt;
        aborted_n = aborted;
        dir_n     = pl_dir_b;
        abort_now = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_n    = SETUP;
                cnt_n      = LD_S;
                gnt_n      = win;
                ptr_n      = win;
                aborted_n  = 1'b0;
                dir_n[win] = dir_req_b[win];
            end
            SETUP, HIGH: if (pfail_b[gnt]) begin
                state_n   = LOW;
                cnt_n     = LD_L;
                aborted_n = 1'b1;
                abort_now = 1'b1;
            end else if (cnt == 16'd0) begin
                state_n = (state == SETUP) ? HIGH : LOW;
                cnt_n   = (state == SETUP) ? LD_H : LD_L;
            end else begin
                cnt_n = cnt - 16'd1;
            end
            default: if (cnt == 16'd0) state_n = IDLE; else cnt_n = cnt - 16'd1;
        endcase
        // outputs are registered from next-state so the pulse and flags are glitch-free
        clk_n = (state_n == HIGH) ? ONE << gnt_n : '0;
        ack_n = (state_n == LOW && cnt_n == 16'd0 && !aborted_n) ? ONE << gnt_n : '0;
        abt_n = abort_now ? ONE << gnt : '0;
    end

    always_ff @(posedge clk_ix or negedge rstn_ix) begin
        if (!rstn_ix) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= PW'(NMOTORS - 1);
            gnt          <= '0;
            aborted      <= 1'b0;
            pl_clk_b     <= '0;
            pl_dir_b     <= '0;
            step_ack_b   <= '0;
            step_abort_b <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ptr          <= ptr_n;
            gnt          <= gnt_n;
            aborted      <= aborted_n;
            pl_clk_b     <= clk_n;
            pl_dir_b     <= dir_n;
            step_ack_b   <= ack_n;
            step_abort_b <= abt_n;
        end
    end
endmodule

// File: tb/tb_motor_step_arbiter.sv
// tb_motor_step_arbiter: scoreboard bench for motor_step_arbiter (defaults plus a minimum-phase instance)
module tb_motor_step_arbiter;
    typedef struct packed {
        logic [1:0]  k;
        logic [3:0]  ch;
        logic [15:0] t;
    } ev_t;
    localparam logic [1:0] K_RISE = 2'd0, K_FALL = 2'd1, K_ACK = 2'd2, K_ABT = 2'd3;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] step_req = '0, dir_req = '0, pfail = '0;
    logic [15:0] pl_clk_b, pl_dir_b, step_ack_b, step_abort_b;
    logic        busy_o;
    logic [15:0] e_req = '0, e_dir = '0, e_pf = '0;
    logic [15:0] e_clk, e_pdir, e_ack, e_abt;
    logic        e_busy;
    int          cyc = 0, base = 0, total = 0, bad = 0, multi_hi = 0;
    logic [15:0] prev_clk = '0;
    ev_t         exp_q[$], obs_q[$];

    motor_step_arbiter u_dut (
        .clk_ix(clk), .rstn_ix(rstn), .step_req_b(step_req), .dir_req_b(dir_req), .pfail_b(pfail),
        .pl_clk_b(pl_clk_b), .pl_dir_b(pl_dir_b), .step_ack_b(step_ack_b), .step_abort_b(step_abort_b),
        .busy_o(busy_o)
    );

    motor_step_arbiter #(.DIR_SETUP_CYC(0), .PULSE_HIGH_CYC(1), .PULSE_LOW_CYC(1)) u_edge (
        .clk_ix(clk), .rstn_ix(rstn), .step_req_b(e_req), .dir_req_b(e_dir), .pfail_b(e_pf),
        .pl_clk_b(e_clk), .pl_dir_b(e_pdir), .step_ack_b(e_ack), .step_abort_b(e_abt),
        .busy_o(e_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] k, input int ch, input int t);
        ev_t r;
        r.k  = k;
        r.ch = 4'(ch);
        r.t  = 16'(t);
        return r;
    endfunction

    task automatic scan;
        for (int i = 0; i < 16; i++) begin
            if (pl_clk_b[i] && !prev_clk[i]) obs_q.push_back(mk(K_RISE, i, cyc - base));
            if (!pl_clk_b[i] && prev_clk[i]) obs_q.push_back(mk(K_FALL, i, cyc - base));
            if (step_ack_b[i]) obs_q.push_back(mk(K_ACK, i, cyc - base));
            if (step_abort_b[i]) obs_q.push_back(mk(K_ABT, i, cyc - base));
        end
        if ($countones(pl_clk_b) > 1) multi_hi++;
        prev_clk = pl_clk_b;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            scan();
        end
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        #1;
        total++; if (pl_clk_b !== 16'h0) begin bad++; $display("FAIL reset_clk got %h required 0000", pl_clk_b); end
        total++; if (pl_dir_b !== 16'h0) begin bad++; $display("FAIL reset_dir got %h required 0000", pl_dir_b); end
        total++; if (step_ack_b !== 16'h0) begin bad++; $display("FAIL reset_ack got %h required 0000", step_ack_b); end
        total++; if (step_abort_b !== 16'h0) begin bad++; $display("FAIL reset_abort got %h required 0000", step_abort_b); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b required 0", busy_o); end
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL reset_edge_busy got %b required 0", e_busy); end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run(3);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got %b required 0", busy_o); end
    endtask

    task automatic test_round_robin;
        ev_t e, o;
        int  chs[5];
        chs = '{0, 2, 15, 0, 2};
        base = cyc;
        for (int s = 0; s < 5; s++) begin
            exp_q.push_back(mk(K_RISE, chs[s], 49 * s + 9));
            exp_q.push_back(mk(K_FALL, chs[s], 49 * s + 29));
            exp_q.push_back(mk(K_ACK, chs[s], 49 * s + 48));
        end
        step_req = 16'h8005;
        dir_req  = 16'h0000;
        run(244);
        step_req = 16'h0000;
        run(2);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rr_busy got %b required 0", busy_o); end
        total++; if (multi_hi !== 0) begin bad++; $display("FAIL rr_onehot got %0d required 0", multi_hi); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL rr_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_single;
        ev_t e, o;
        base = cyc;
        exp_q.push_back(mk(K_RISE, 0, 9));
        exp_q.push_back(mk(K_FALL, 0, 29));
        exp_q.push_back(mk(K_ACK, 0, 48));
        step_req = 16'h0001;
        dir_req  = 16'h0001;
        run(1);
        total++; if (pl_dir_b !== 16'h0001) begin bad++; $display("FAIL single_dir got %h required 0001", pl_dir_b); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy got %b required 1", busy_o); end
        dir_req = 16'h0000;
        run(47);
        step_req = 16'h0000;
        run(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got %b required 0", busy_o); end
        total++; if (pl_dir_b !== 16'h0001) begin bad++; $display("FAIL single_dir_hold got %h required 0001", pl_dir_b); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL single_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_abort;
        ev_t e, o;
        base = cyc;
        exp_q.push_back(mk(K_RISE, 3, 9));
        exp_q.push_back(mk(K_FALL, 3, 16));
        exp_q.push_back(mk(K_ABT, 3, 16));
        step_req = 16'h0008;
        dir_req  = 16'h0008;
        run(15);
        pfail = 16'h0008;
        run(1);
        total++; if (pl_clk_b !== 16'h0000) begin bad++; $display("FAIL abort_clk got %h required 0000", pl_clk_b); end
        total++; if (step_abort_b !== 16'h0008) begin bad++; $display("FAIL abort_flag got %h required 0008", step_abort_b); end
        step_req = 16'h0000;
        run(1);
        total++; if (step_abort_b !== 16'h0000) begin bad++; $display("FAIL abort_one_cycle got %h required 0000", step_abort_b); end
        pfail = 16'h0000;
        run(18);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL abort_low_busy got %b required 1", busy_o); end
        total++; if (step_ack_b !== 16'h0000) begin bad++; $display("FAIL abort_no_ack got %h required 0000", step_ack_b); end
        run(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle got %b required 0", busy_o); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL abort_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_pfail_low;
        ev_t e, o;
        base = cyc;
        exp_q.push_back(mk(K_RISE, 1, 9));
        exp_q.push_back(mk(K_FALL, 1, 29));
        exp_q.push_back(mk(K_ACK, 1, 48));
        step_req = 16'h0002;
        run(2);
        step_req = 16'h0000;
        run(33);
        pfail = 16'h0002;
        run(13);
        total++; if (step_ack_b !== 16'h0002) begin bad++; $display("FAIL lowpf_ack got %h required 0002", step_ack_b); end
        pfail = 16'h0000;
        run(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL lowpf_idle got %b required 0", busy_o); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL lowpf_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_masking;
        ev_t e, o;
        base = cyc;
        exp_q.push_back(mk(K_RISE, 5, 9));
        exp_q.push_back(mk(K_FALL, 5, 29));
        exp_q.push_back(mk(K_ACK, 5, 48));
        step_req = 16'h0030;
        pfail    = 16'h0010;
        run(48);
        step_req = 16'h0000;
        pfail    = 16'h0000;
        run(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mask_idle got %b required 0", busy_o); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL mask_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_reset_mid_pulse;
        ev_t e, o;
        base = cyc;
        step_req = 16'h0080;
        dir_req  = 16'h0080;
        run(12);
        total++; if (pl_clk_b !== 16'h0080) begin bad++; $display("FAIL mid_high got %h required 0080", pl_clk_b); end
        #2 rstn = 1'b0;
        #1;
        total++; if (pl_clk_b !== 16'h0000) begin bad++; $display("FAIL mid_clk got %h required 0000", pl_clk_b); end
        total++; if (pl_dir_b !== 16'h0000) begin bad++; $display("FAIL mid_dir got %h required 0000", pl_dir_b); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy got %b required 0", busy_o); end
        step_req = 16'h0081;
        dir_req  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        obs_q.delete();
        prev_clk = pl_clk_b;
        rstn = 1'b1;
        base = cyc;
        exp_q.push_back(mk(K_RISE, 0, 9));
        exp_q.push_back(mk(K_FALL, 0, 29));
        exp_q.push_back(mk(K_ACK, 0, 48));
        run(48);
        step_req = 16'h0000;
        run(1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_idle got %b required 0", busy_o); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = mk(K_ABT, 15, 16'hffff);
            o = e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL mid_event got k=%0d ch=%0d t=%0d required k=%0d ch=%0d t=%0d", o.k, o.ch, o.t, e.k, e.ch, e.t); end
        end
    endtask

    task automatic test_edge_params;
        e_req = 16'h0001;
        run(1);
        total++; if (e_clk !== 16'h0000) begin bad++; $display("FAIL edge_setup_clk got %h required 0000", e_clk); end
        total++; if (e_busy !== 1'b1) begin bad++; $display("FAIL edge_busy got %b required 1", e_busy); end
        run(1);
        total++; if (e_clk !== 16'h0001) begin bad++; $display("FAIL edge_high got %h required 0001", e_clk); end
        total++; if (e_ack !== 16'h0000) begin bad++; $display("FAIL edge_early_ack got %h required 0000", e_ack); end
        run(1);
        total++; if (e_clk !== 16'h0000) begin bad++; $display("FAIL edge_low_clk got %h required 0000", e_clk); end
        total++; if (e_ack !== 16'h0001) begin bad++; $display("FAIL edge_ack got %h required 0001", e_ack); end
        e_req = 16'h0000;
        run(1);
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL edge_idle got %b required 0", e_busy); end
        total++; if (e_ack !== 16'h0000) begin bad++; $display("FAIL edge_ack_once got %h required 0000", e_ack); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_abort();
        test_pfail_low();
        test_masking();
        test_reset_mid_pulse();
        test_edge_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
